// File: rtl/wait_fork_n_if.sv
// Drive/free handshake bundle between a producer stage, the fork, and its
// downstream branches. Names keep the i_/o_ prefixes as seen from the fork.
// The slave modport is the fork itself; the master modport is the environment.
//
// Handshake semantics: i_drive, o_drive, i_free and o_free are single-cycle
// event pulses, not level valid/ready pairs. An event counts in the cycle
// its pulse is high, and there is no back-pressure. i_mask is only
// meaningful in the cycle i_drive is accepted.
interface wait_fork_n_if #(
  parameter int N = 2
);
  logic         i_drive;
  logic [N-1:0] i_mask;
  logic         o_free;
  logic [N-1:0] o_drive;
  logic [N-1:0] i_free;
  logic [N-1:0] o_pending;
  logic         o_busy;
  logic         o_err;

  modport slave (
    input  i_drive, i_mask, i_free,
    output o_free, o_drive, o_pending, o_busy, o_err
  );

  modport master (
    output i_drive, i_mask, i_free,
    input  o_free, o_drive, o_pending, o_busy, o_err
  );
endinterface

// File: rtl/wait_fork_n.sv
// N-way fork for the drive/free event handshake.
// One upstream drive fans out to the branches selected by i_mask after
// DRV_DLY cycles. A single upstream free is returned once every selected
// branch has freed, in any order. All outputs come from registered state only.
module wait_fork_n #(
  parameter int N       = 2,
  parameter int DRV_DLY = 1
) (
  input  logic          clk,
  input  logic          rst,
  wait_fork_n_if.slave  bus,
  output logic [2:0]    state_dbg
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DELAY   = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // Value loaded into the delay counter on accept. DELAY leaves when it reads 1.
  localparam logic [3:0] DLY_LOAD = 4'(DRV_DLY - 1);

  logic [2:0]   state, state_n;
  logic [3:0]   cnt, cnt_n;
  logic [N-1:0] mask_q, mask_n;
  logic [N-1:0] pending, pending_n;
  logic         err, err_n;

  // State for a newly accepted drive, shared by IDLE and RELEASE.
  logic [2:0]   acc_state;
  logic [3:0]   acc_cnt;

  // Decode where an accepted drive goes, based on the live mask.
  always_comb begin
    acc_state = ST_RELEASE;
    acc_cnt   = 4'd0;
    if (bus.i_mask != '0) begin
      if (DRV_DLY == 1) begin
        acc_state = ST_ISSUE;
      end else begin
        acc_state = ST_DELAY;
        acc_cnt   = DLY_LOAD;
      end
    end
  end

  // Next-state, pending and error logic. An error never changes anything but err.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mask_n    = mask_q;
    pending_n = pending;
    err_n     = err;
    case (state)
      ST_IDLE, ST_RELEASE: begin
        if (bus.i_free != '0) err_n = 1'b1;
        if (bus.i_drive) begin
          mask_n  = bus.i_mask;
          cnt_n   = acc_cnt;
          state_n = acc_state;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (bus.i_drive || (bus.i_free != '0)) err_n = 1'b1;
        if (cnt == 4'd1) begin
          cnt_n   = 4'd0;
          state_n = ST_ISSUE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_ISSUE: begin
        // A zero-latency consumer may free in the same cycle as its drive.
        if (bus.i_drive || ((bus.i_free & ~mask_q) != '0)) err_n = 1'b1;
        pending_n = mask_q & ~bus.i_free;
        state_n   = (pending_n == '0) ? ST_RELEASE : ST_WAIT;
      end
      ST_WAIT: begin
        // Legal bits are consumed even when an illegal bit arrives alongside.
        if (bus.i_drive || ((bus.i_free & ~pending) != '0)) err_n = 1'b1;
        pending_n = pending & ~bus.i_free;
        if (pending_n == '0) state_n = ST_RELEASE;
      end
      default: begin
        state_n   = ST_IDLE;
        cnt_n     = 4'd0;
        pending_n = '0;
      end
    endcase
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      mask_q  <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      mask_q  <= mask_n;
      pending <= pending_n;
      err     <= err_n;
    end
  end

  assign bus.o_drive   = (state == ST_ISSUE) ? mask_q : '0;
  assign bus.o_free    = (state == ST_RELEASE);
  assign bus.o_busy    = (state == ST_DELAY) || (state == ST_ISSUE) || (state == ST_WAIT);
  assign bus.o_pending = pending;
  assign bus.o_err     = err;
  assign state_dbg     = state;

endmodule

// File: tb/tb_wait_fork_n.sv
// Directed bench for wait_fork_n: a 2-branch/1-cycle instance (a) and a
// 4-branch/3-cycle instance (b) on a shared clock and reset.
// Inputs change 1ns after posedge; outputs are checked on the negedge.
module tb_wait_fork_n;

  logic       clk;
  logic       rst;
  logic [2:0] st_a, st_b;
  int         total;
  int         bad;

  wait_fork_n_if #(.N(2)) bus_a ();
  wait_fork_n_if #(.N(4)) bus_b ();

  wait_fork_n #(.N(2), .DRV_DLY(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .state_dbg(st_a)
  );
  wait_fork_n #(.N(4), .DRV_DLY(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .state_dbg(st_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enter the next cycle: inputs set after this are sampled at the next posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_a();
    bus_a.i_drive = 1'b0;
    bus_a.i_mask  = '0;
    bus_a.i_free  = '0;
  endtask

  task automatic idle_b();
    bus_b.i_drive = 1'b0;
    bus_b.i_mask  = '0;
    bus_b.i_free  = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_a();
    idle_b();

    // Reset state
    #12;
    chk("rst_a_free",    32'(bus_a.o_free), 0);
    chk("rst_a_drive",   32'(bus_a.o_drive), 0);
    chk("rst_a_pending", 32'(bus_a.o_pending), 0);
    chk("rst_a_busy",    32'(bus_a.o_busy), 0);
    chk("rst_a_err",     32'(bus_a.o_err), 0);
    chk("rst_a_state",   32'(st_a), 0);
    chk("rst_b_busy",    32'(bus_b.o_busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: N=2, mask 11, frees 01 then 10
    tick(); bus_a.i_drive = 1'b1; bus_a.i_mask = 2'b11;           // t0
    sample(); chk("t1_t0_busy", 32'(bus_a.o_busy), 0);
    tick(); idle_a();                                               // t1
    sample(); chk("t1_t1_drive", 32'(bus_a.o_drive), 2'b11);
    chk("t1_t1_busy", 32'(bus_a.o_busy), 1);
    chk("t1_t1_state", 32'(st_a), 2);
    tick();                                                         // t2
    sample(); chk("t1_t2_drive", 32'(bus_a.o_drive), 0);
    chk("t1_t2_pending", 32'(bus_a.o_pending), 2'b11);
    tick(); bus_a.i_free = 2'b01;                                   // t3
    sample(); chk("t1_t3_free", 32'(bus_a.o_free), 0);
    tick(); idle_a();                                               // t4
    sample(); chk("t1_t4_pending", 32'(bus_a.o_pending), 2'b10);
    tick(); bus_a.i_free = 2'b10;                                   // t5
    sample(); chk("t1_t5_free", 32'(bus_a.o_free), 0);
    tick(); idle_a();                                               // t6
    sample(); chk("t1_t6_free", 32'(bus_a.o_free), 1);
    chk("t1_t6_pending", 32'(bus_a.o_pending), 0);
    chk("t1_t6_busy", 32'(bus_a.o_busy), 0);
    tick();                                                         // t7
    sample(); chk("t1_t7_free", 32'(bus_a.o_free), 0);
    chk("t1_err", 32'(bus_a.o_err), 0);

    // T2: N=4, DRV_DLY=3, mask 0101, zero-latency frees
    tick(); bus_b.i_drive = 1'b1; bus_b.i_mask = 4'b0101;         // t0
    sample(); chk("t2_t0_busy", 32'(bus_b.o_busy), 0);
    tick(); idle_b();                                               // t1
    sample(); chk("t2_t1_busy", 32'(bus_b.o_busy), 1);
    chk("t2_t1_drive", 32'(bus_b.o_drive), 0);
    chk("t2_t1_state", 32'(st_b), 1);
    tick();                                                         // t2
    sample(); chk("t2_t2_busy", 32'(bus_b.o_busy), 1);
    chk("t2_t2_drive", 32'(bus_b.o_drive), 0);
    tick(); bus_b.i_free = 4'b0101;                                 // t3
    sample(); chk("t2_t3_drive", 32'(bus_b.o_drive), 4'b0101);
    chk("t2_t3_busy", 32'(bus_b.o_busy), 1);
    tick(); idle_b();                                               // t4
    sample(); chk("t2_t4_free", 32'(bus_b.o_free), 1);
    chk("t2_t4_drive", 32'(bus_b.o_drive), 0);
    chk("t2_t4_busy", 32'(bus_b.o_busy), 0);
    tick();                                                         // t5
    sample(); chk("t2_t5_free", 32'(bus_b.o_free), 0);
    chk("t2_err", 32'(bus_b.o_err), 0);

    // T3: empty mask, then back-to-back accept from RELEASE
    tick(); bus_a.i_drive = 1'b1; bus_a.i_mask = 2'b00;           // t0
    sample();
    tick(); bus_a.i_drive = 1'b1; bus_a.i_mask = 2'b11;           // t1
    sample(); chk("t3_t1_free", 32'(bus_a.o_free), 1);
    chk("t3_t1_drive", 32'(bus_a.o_drive), 0);
    tick(); idle_a();                                               // t2
    sample(); chk("t3_t2_drive", 32'(bus_a.o_drive), 2'b11);
    chk("t3_t2_free", 32'(bus_a.o_free), 0);
    tick(); bus_a.i_free = 2'b11;                                   // t3
    sample(); chk("t3_t3_pending", 32'(bus_a.o_pending), 2'b11);
    tick(); idle_a();                                               // t4
    sample(); chk("t3_t4_free", 32'(bus_a.o_free), 1);
    tick();                                                         // t5
    sample(); chk("t3_t5_state", 32'(st_a), 0);
    chk("t3_err", 32'(bus_a.o_err), 0);

    // T4: drive during WAIT plus a free on an unmasked branch
    tick(); bus_a.i_drive = 1'b1; bus_a.i_mask = 2'b01;           // t0
    sample();
    tick(); idle_a();                                               // t1 ISSUE
    sample(); chk("t4_t1_drive", 32'(bus_a.o_drive), 2'b01);
    tick(); bus_a.i_drive = 1'b1; bus_a.i_mask = 2'b11;           // t2 WAIT
    bus_a.i_free = 2'b10;
    sample(); chk("t4_t2_err", 32'(bus_a.o_err), 0);
    tick(); idle_a(); bus_a.i_free = 2'b01;                         // t3
    sample(); chk("t4_t3_err", 32'(bus_a.o_err), 1);
    chk("t4_t3_pending", 32'(bus_a.o_pending), 2'b01);
    chk("t4_t3_state", 32'(st_a), 3);
    tick(); idle_a();                                               // t4
    sample(); chk("t4_t4_free", 32'(bus_a.o_free), 1);
    for (int i = 0; i < 3; i++) begin                               // t5..t7
      tick();
      sample(); chk("t4_free_once", 32'(bus_a.o_free), 0);
      chk("t4_no_drive", 32'(bus_a.o_drive), 0);
    end
    chk("t4_err_sticky", 32'(bus_a.o_err), 1);

    // T5: reset in WAIT with pending 10
    tick(); bus_a.i_drive = 1'b1; bus_a.i_mask = 2'b11;           // t0
    sample();
    tick(); idle_a();                                               // t1
    sample();
    tick(); bus_a.i_free = 2'b01;                                   // t2
    sample();
    tick(); idle_a();                                               // t3
    sample(); chk("t5_pending_before", 32'(bus_a.o_pending), 2'b10);
    rst = 1'b1;
    #1;
    chk("t5_async_pending", 32'(bus_a.o_pending), 0);
    chk("t5_async_busy",    32'(bus_a.o_busy), 0);
    chk("t5_async_err",     32'(bus_a.o_err), 0);
    chk("t5_async_state",   32'(st_a), 0);
    bus_a.i_free = 2'b10;
    tick();
    sample(); chk("t5_rst_free", 32'(bus_a.o_free), 0);
    idle_a();
    tick(); rst = 1'b0;
    sample(); chk("t5_post_free", 32'(bus_a.o_free), 0);
    tick(); bus_a.i_drive = 1'b1; bus_a.i_mask = 2'b10;           // fresh t0
    sample();
    tick(); idle_a(); bus_a.i_free = 2'b10;                         // t1
    sample(); chk("t5_fresh_drive", 32'(bus_a.o_drive), 2'b10);
    tick(); idle_a();                                               // t2
    sample(); chk("t5_fresh_free", 32'(bus_a.o_free), 1);
    chk("t5_fresh_err", 32'(bus_a.o_err), 0);
    tick();
    sample(); chk("t5_end_state", 32'(st_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global timeout
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wait_fork_n.md
Name: wait_fork_n

Overview:
- Clocked N-way fork for the drive/free event handshake. It is the split-side counterpart of the two-way wait-merge join.
- One upstream drive event fans out as drive pulses to a selected set of downstream branches.
- The block collects one free event from every selected branch, in any order, before returning a single free event upstream.
- It sits between a producer stage and several parallel consumer stages in the synchronous control fabric.

Parameters:
- N, 2, number of downstream branches (2..16).
- DRV_DLY, 1, cycles from accepted i_drive to o_drive pulse (1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- i_drive  input  1  upstream drive event, single-cycle high pulse.
- i_mask  input  N  branch select, sampled only in the cycle i_drive is accepted.
- o_free  output  1  upstream free event, single-cycle pulse.
- o_drive  output  N  per-branch drive pulse, single cycle.
- i_free  input  N  per-branch free event, single-cycle pulse.
- o_pending  output  N  branches still owing a free.
- o_busy  output  1  high in every state except IDLE and RELEASE.
- o_err  output  1  sticky protocol-error flag; cleared only by rst.

Behaviour:
- Reset: all outputs 0, state IDLE, pending 0, delay counter 0. Reset asserted mid-transaction aborts it; no o_free is issued afterwards.
- States: IDLE, DELAY, ISSUE, WAIT, RELEASE.
- Accept rule: i_drive is accepted only in IDLE or RELEASE, so back-to-back transactions are allowed. On accept, mask_q <= i_mask.
- Accept with i_mask == 0: go to RELEASE. o_free = 1 at t+1. No o_drive is issued.
- Accept with i_mask != 0:
  - DRV_DLY == 1: go to ISSUE.
  - DRV_DLY > 1: go to DELAY, counter = DRV_DLY-1. DELAY decrements each cycle and goes to ISSUE when the counter reaches 1.
- ISSUE (one cycle): o_drive = mask_q; pending <= mask_q & ~i_free. i_free may arrive in the same cycle as o_drive (zero-latency consumer) and counts.
  - Resulting pending == 0: go to RELEASE.
  - Otherwise: go to WAIT.
- Latency summary: i_drive at cycle t gives o_drive at t+DRV_DLY. o_free comes one cycle after the cycle in which the last required free is sampled.
- WAIT: pending <= pending & ~i_free. Multiple simultaneous frees are legal. Go to RELEASE when pending & ~i_free == 0.
- RELEASE (one cycle): o_free = 1. Next state:
  - i_drive high: treated as a new accept, as above.
  - Otherwise: IDLE.
- o_pending shows the registered pending vector (0 in IDLE, DELAY and RELEASE).
- Errors set o_err = 1 and change no other state:
  - i_drive in DELAY, ISSUE or WAIT: the event is dropped.
  - Any i_free bit in IDLE, DELAY or RELEASE.
  - Any i_free bit in ISSUE/WAIT for a branch not in pending/mask_q.
  - In WAIT, a legal free and an illegal free in the same cycle: the legal bit is still consumed.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.

Test Plan:
- N=2, DRV_DLY=1, i_drive+i_mask=2'b11 at t=0; i_free=01 at t=3, 10 at t=5 -> o_drive=11 at t=1, o_pending=10 at t=4, o_free=1 at t=6, o_err=0.
- N=4, DRV_DLY=3, i_mask=4'b0101; i_free=0101 at t=3 (same cycle as o_drive) -> o_drive=0101 only at t=3, o_free at t=4, o_busy high t=1..3.
- i_mask=0 with i_drive at t=0 -> no o_drive, o_free at t=1; i_drive again at t=1 with mask=11 -> accepted, o_drive=11 at t=2.
- i_drive during WAIT, and i_free on an unmasked branch -> o_err latches 1, transaction completes normally, o_free issued exactly once.
- Assert rst in WAIT with o_pending=10 -> all outputs 0 immediately, no o_free; after release, a fresh transaction completes normally; o_err cleared.
